// File: rtl/fifo_router_pkg.sv
// fifo_router_pkg: shared state encoding and channel geometry for the router
package fifo_router_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, WAIT = 2'd2, ROUTE = 2'd3} state_t;
  localparam int DEST_W = 2;
  localparam int N_CH = 4;
endpackage

// File: rtl/fifo_router_route_counter.sv
// route_counter: wrapping per-destination packet counter
module route_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_L,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) cnt <= '0;
    else cnt <= inc ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/fifo_router.sv
// fifo_router: pops words from the input FIFO and pushes each to its destination FIFO
module fifo_router
  import fifo_router_pkg::*;
#(
  parameter int WORD_SIZE = 10,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_L,
  input  logic                   enable,
  input  logic                   src_empty,
  input  logic [WORD_SIZE-1:0]   src_data,
  output logic                   src_pop,
  input  logic [N_CH-1:0]        dst_full,
  output logic [N_CH-1:0]        dst_push,
  output logic [WORD_SIZE-1:0]   dst_data,
  output logic                   idle,
  output logic [N_CH*CNT_W-1:0]  pkt_cnt
);
  state_t state;
  logic [WORD_SIZE-1:0] word;
  logic [DEST_W-1:0] dest;
  logic go, fire;
  assign dest = word[WORD_SIZE-1 -: DEST_W];
  assign go = enable && !src_empty;
  assign fire = state == ROUTE && !dst_full[dest];
  assign src_pop = state == FETCH;
  assign dst_push = fire ? N_CH'(1) << dest : '0;
  assign idle = state == IDLE;
  assign dst_data = word;
  // a blocked word holds the FSM in ROUTE: strict in-order delivery
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) begin
      state <= IDLE;
      word <= '0;
    end else begin
      state <= state == IDLE  ? (go ? FETCH : IDLE) :
               state == FETCH ? WAIT :
               state == WAIT  ? ROUTE :
               fire           ? (go ? FETCH : IDLE) : ROUTE;
      word <= state == WAIT ? src_data : word;
    end
  for (genvar i = 0; i < N_CH; i++) begin : g_cnt
    route_counter #(.W(CNT_W)) u_cnt (
      .clk(clk),
      .reset_L(reset_L),
      .inc(dst_push[i]),
      .cnt(pkt_cnt[i*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_fifo_router.sv
// tb_fifo_router: directed checks of fetch/route timing, back-pressure, enable and wrap
module tb_fifo_router;
  logic clk = 0, reset_L = 0, enable = 0;
  logic src_empty, src_pop, idle;
  logic [9:0] src_data = '0, dst_data;
  logic [3:0] dst_full = '0, dst_push;
  logic [31:0] pkt_cnt;
  logic [9:0] mem [512];
  int wp = 0, rp = 0, cyc = 0, n3 = 0, tests = 0, fails = 0;
  int t [4];
  int tb0, base, n;

  fifo_router dut (
    .clk(clk), .reset_L(reset_L), .enable(enable), .src_empty(src_empty),
    .src_data(src_data), .src_pop(src_pop), .dst_full(dst_full),
    .dst_push(dst_push), .dst_data(dst_data), .idle(idle), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;
  assign src_empty = (wp == rp);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dst_push[3]) n3 <= n3 + 1;
    if (src_pop) begin
      src_data <= mem[rp % 512];
      rp <= rp + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [9:0] w);
    mem[wp % 512] = w;
    wp++;
  endtask

  task automatic wait_push(input string tag, input logic [3:0] ep, input logic [9:0] ed, output int at);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (dst_push == 0 && k < 20);
    check({tag, "_push"}, dst_push, ep);
    check({tag, "_data"}, dst_data, ed);
    at = cyc;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_idle", idle, 1);
    check("rst_pop", src_pop, 0);
    check("rst_push", dst_push, 0);
    check("rst_cnt", pkt_cnt, 0);
    check("rst_data", dst_data, 0);
    reset_L = 1;
    enable = 1;
    // single word: pop, capture, push on consecutive cycles
    put(10'h2A5);
    @(negedge clk); check("single_pop", src_pop, 1);
    @(negedge clk); check("single_wait_pop", src_pop, 0);
    check("single_wait_push", dst_push, 0);
    @(negedge clk); check("single_push", dst_push, 4'b0100);
    check("single_data", dst_data, 10'h2A5);
    @(negedge clk); check("single_cnt", pkt_cnt, 32'h00010000);
    check("single_idle", idle, 1);
    // stream to all four destinations, one word per 3 cycles
    put(10'h005); put(10'h10A); put(10'h20F); put(10'h3C3);
    wait_push("s0", 4'b0001, 10'h005, t[0]);
    wait_push("s1", 4'b0010, 10'h10A, t[1]);
    wait_push("s2", 4'b0100, 10'h20F, t[2]);
    wait_push("s3", 4'b1000, 10'h3C3, t[3]);
    for (int i = 1; i < 4; i++) check("s_gap", t[i] - t[i-1], 3);
    @(negedge clk); check("s_idle", idle, 1);
    check("s_cnt", pkt_cnt, 32'h01020101);
    // back-pressure on dest 1 for 5 cycles
    dst_full = 4'b0010;
    put(10'h155); put(10'h0AA);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_nopush", dst_push, 0);
      check("bp_nopop", src_pop, 0);
      check("bp_busy", idle, 0);
      @(negedge clk);
    end
    dst_full = 4'b0000;
    #1;
    check("bp_release_push", dst_push, 4'b0010);
    check("bp_release_data", dst_data, 10'h155);
    wait_push("bp_next", 4'b0001, 10'h0AA, tb0);
    @(negedge clk); check("bp_cnt", pkt_cnt, 32'h01020202);
    // enable dropped during WAIT: current word finishes, second waits
    put(10'h2F0); put(10'h301);
    @(negedge clk);
    @(negedge clk); enable = 0;
    @(negedge clk); check("en_push", dst_push, 4'b0100);
    check("en_data", dst_data, 10'h2F0);
    @(negedge clk); check("en_idle", idle, 1);
    repeat (4) begin
      @(negedge clk);
      check("en_hold_pop", src_pop, 0);
      check("en_hold_idle", idle, 1);
    end
    enable = 1;
    wait_push("en_resume", 4'b1000, 10'h301, tb0);
    @(negedge clk); check("en_cnt", pkt_cnt, 32'h02030202);
    // reset asserted while a push is pending in ROUTE
    put(10'h0FF);
    repeat (3) @(negedge clk);
    check("mid_route_push", dst_push, 4'b0001);
    reset_L = 0;
    #1;
    check("mid_rst_push", dst_push, 0);
    check("mid_rst_pop", src_pop, 0);
    check("mid_rst_idle", idle, 1);
    check("mid_rst_cnt", pkt_cnt, 0);
    check("mid_rst_data", dst_data, 0);
    @(negedge clk); reset_L = 1;
    repeat (3) @(negedge clk);
    check("post_rst_cnt", pkt_cnt, 0);
    check("post_rst_idle", idle, 1);
    // 256 words to dest 3 wrap its counter back to zero
    base = n3;
    for (int i = 0; i < 256; i++) put({2'b11, 8'(i)});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(idle && src_empty) && n < 2000);
    check("wrap_done", n < 2000, 1);
    check("wrap_pushes", n3 - base, 256);
    check("wrap_cnt", pkt_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_router.md
# fifo_router

Downstream consumer of the input FIFO: pops one 10-bit word at a time, decodes destination bits [9:8], and pushes the word into one of four per-destination output FIFOs. Honours back-pressure per destination and keeps a per-destination packet counter for the bench and status logic. Sits between the input FIFO read port and the four destination FIFO write ports.

## Interface

- WORD_SIZE, 10, word width; [WORD_SIZE-1:WORD_SIZE-2] = destination, [WORD_SIZE-3:0] = data
- CNT_W, 8, width of each per-destination packet counter
- clk  in  1  single clock, all logic on rising edge
- reset_L  in  1  asynchronous, active-low reset
- enable  in  1  1 = new fetches allowed; 0 = finish in-flight word, then hold in IDLE
- src_empty  in  1  input FIFO empty flag
- src_data  in  WORD_SIZE  input FIFO read data, valid one cycle after src_pop
- src_pop  out  1  read strobe to input FIFO, one cycle wide
- dst_full  in  4  full flag of destination FIFO 0..3
- dst_push  out  4  one-hot write strobe to destination FIFO 0..3
- dst_data  out  WORD_SIZE  word being written (whole word, destination bits included)
- idle  out  1  1 while in IDLE
- pkt_cnt  out  4*CNT_W  packet counters, destination d at [d*CNT_W +: CNT_W]

## Operation

- FSM states: IDLE, FETCH, WAIT, ROUTE.
- IDLE: src_pop=0, dst_push=0. Go to FETCH when enable && !src_empty; else stay.
- FETCH: src_pop=1 for exactly this cycle; always go to WAIT.
- WAIT: src_data is valid; capture into word register at the end of the cycle; go to ROUTE.
- ROUTE: dest = word[WORD_SIZE-1:WORD_SIZE-2]; dst_data = word.
  - If !dst_full[dest]: dst_push[dest]=1 this cycle, pkt_cnt[dest] += 1. Next state is FETCH if enable && !src_empty, else IDLE.
  - If dst_full[dest]: no push; stay in ROUTE holding the word until space appears. No other destination is served meanwhile (in-order, head-of-line blocking by design).
- enable only gates the IDLE→FETCH and ROUTE→FETCH decisions; deassertion never aborts FETCH, WAIT or ROUTE.
- src_pop is never asserted while src_empty was 1 at the decision cycle.
- dst_push is one-hot or zero, never multi-hot.
- pkt_cnt: unsigned, wraps from 2^CNT_W-1 to 0, no saturation.
- dst_data outside ROUTE: holds last captured word (don't-care for consumers, but deterministic).

## Timing

- Reset (reset_L=0, asynchronous): state=IDLE, src_pop=0, dst_push=0, dst_data=0, word=0, pkt_cnt all 0, idle=1. Reset mid-transfer drops the in-flight word; it is neither pushed nor counted.
- src_pop, dst_push, idle: decoded from state (and dst_full in ROUTE); no extra register stage.
- Latency: src_empty falling at cycle t (enable=1, in IDLE) → src_pop at t+1 → capture at t+2 → dst_push at t+3 when destination not full.
- Throughput: one word per 3 cycles when streaming (ROUTE→FETCH→WAIT→ROUTE).
- dst_full sampled combinationally in ROUTE; push occurs in the same cycle it is seen low.
- Counter increments are visible the cycle after the push.

## Structure

- Shared include: state encodings (IDLE=2'd0, FETCH=2'd1, WAIT=2'd2, ROUTE=2'd3), destination field width (2), channel count (4).
- Sub-module route_counter: one CNT_W-bit counter with async active-low reset and increment enable, instantiated 4×.
- FSM, word register and one-hot decode stay in fifo_router.

## Test plan

- Reset: drive reset_L=0 mid-ROUTE with dst_full=4'b0000 → immediately src_pop=0, dst_push=0, pkt_cnt=0, idle=1; the pending word is never pushed.
- Single word: preload input FIFO with 10'b10_1010_0101, enable=1 → src_pop one cycle, then dst_push=4'b0100, dst_data=10'h2A5 two cycles later, pkt_cnt[2]=1.
- Stream: 4 words to dest 0,1,2,3 → pushes 4'b0001,0010,0100,1000 in order, spaced 3 cycles, each counter = 1, then idle=1.
- Back-pressure: word to dest 1 with dst_full[1]=1 for 5 cycles → stays in ROUTE, no push, no src_pop; dst_full[1]→0 → push in that same cycle, then continues.
- Enable drop: deassert enable during WAIT with 2 words queued → current word pushed, FSM returns to IDLE, second word not popped until enable=1.
- Wrap: 256 words to dest 3 (CNT_W=8) → pkt_cnt[3] returns to 0, others stay 0.
